audio_frame_writer: RTL and testbench

//  Upstream stage of the DSP sequencer. Accepts per-channel 16-bit audio samples and writes

---
 rtl/audio_frame_writer_if.sv | 12 +
 rtl/audio_frame_writer.sv | 174 +++++++++++++++++
 tb/tb_audio_frame_writer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_writer_if.sv
// Sample stream into audio_frame_writer: valid/ready handshake carrying a channel index and a 16-bit sample.
interface audio_frame_writer_if #(
   parameter int CHAN_W = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [CHAN_W-1:0] in_chan;
   logic [15:0]       in_data;

   modport master (output in_valid, in_chan, in_data, input in_ready);
   modport slave  (input in_valid, in_chan, in_data, output in_ready);
endinterface

// File: rtl/audio_frame_writer.sv
// Collects one sample per channel into the audio RAM ring, then runs the sequencer on that frame.
// Optional feature: define AUDIO_FRAME_WRITER_OVERRUN_EN for always-ready input with dropped-sample counting.
module audio_frame_writer #(
   parameter int CHAN_W  = 3,
   parameter int FRAME_W = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                        ck,
   input  logic                        rst,
   audio_frame_writer_if.slave         in_if,
   output logic                        wr_en,
   output logic [CHAN_W+FRAME_W-1:0]   wr_addr,
   output logic [15:0]                 wr_data,
   output logic [FRAME_W-1:0]          frame,
   output logic                        seq_run,
   input  logic                        seq_done,
   input  logic                        seq_error,
   output logic [15:0]                 frame_count,
   output logic                        err
`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
   ,
   output logic [15:0]                 overrun_count
`endif
);

   localparam int NCHAN = 2**CHAN_W;

   localparam logic [1:0] S_GAP     = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_START   = 2'd2;
   localparam logic [1:0] S_RUN     = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic                        gap_cnt_q, gap_cnt_d;
   logic [NCHAN-1:0]            mask_q, mask_d;
   logic [FRAME_W-1:0]          wr_frame_q, wr_frame_d;
   logic [9:0]                  tmo_cnt_q, tmo_cnt_d;
   logic                        wr_en_q, wr_en_d;
   logic [CHAN_W+FRAME_W-1:0]   wr_addr_q, wr_addr_d;
   logic [15:0]                 wr_data_q, wr_data_d;
   logic [FRAME_W-1:0]          frame_q, frame_d;
   logic                        seq_run_q, seq_run_d;
   logic [15:0]                 frame_count_q, frame_count_d;
   logic                        err_q, err_d;
   logic                        ready;
   logic                        accept;

`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
   logic        ready_q, ready_d;
   logic [15:0] overrun_q, overrun_d;

   assign ready         = ready_q;
   assign overrun_count = overrun_q;
`else
   assign ready = (state_q == S_COLLECT);
`endif

   assign accept         = in_if.in_valid & ready;
   assign in_if.in_ready = ready;

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame       = frame_q;
   assign seq_run     = seq_run_q;
   assign frame_count = frame_count_q;
   assign err         = err_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d       = state_q;
      gap_cnt_d     = gap_cnt_q;
      mask_d        = mask_q;
      wr_frame_d    = wr_frame_q;
      tmo_cnt_d     = tmo_cnt_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_d       = frame_q;
      seq_run_d     = seq_run_q;
      frame_count_d = frame_count_q;
      err_d         = err_q;
`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
      ready_d   = 1'b1;
      overrun_d = overrun_q;
      if (accept && (state_q != S_COLLECT) && (overrun_q != 16'hFFFF))
         overrun_d = overrun_q + 16'd1;
`endif

      case (state_q)
         S_GAP: begin
            // Two clocks minimum, and the sequencer's done must have fallen first.
            gap_cnt_d = 1'b1;
            if (gap_cnt_q && !seq_done)
               state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {in_if.in_chan, wr_frame_q};
               wr_data_d = in_if.in_data;
               if (mask_q[in_if.in_chan])
                  err_d = 1'b1;
               mask_d[in_if.in_chan] = 1'b1;
               if (&mask_d)
                  state_d = S_START;
            end
         end
         S_START: begin
            frame_d   = wr_frame_q;
            seq_run_d = 1'b1;
            tmo_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
            if (seq_done || (tmo_cnt_d == 10'(TIMEOUT))) begin
               seq_run_d  = 1'b0;
               wr_frame_d = wr_frame_q + FRAME_W'(1);
               mask_d     = '0;
               gap_cnt_d  = 1'b0;
               state_d    = S_GAP;
               if (seq_done) begin
                  frame_count_d = frame_count_q + 16'd1;
                  if (seq_error)
                     err_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_GAP;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q       <= S_GAP;
         gap_cnt_q     <= 1'b0;
         mask_q        <= '0;
         wr_frame_q    <= '0;
         tmo_cnt_q     <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_q       <= '0;
         seq_run_q     <= 1'b0;
         frame_count_q <= '0;
         err_q         <= 1'b0;
`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
         ready_q       <= 1'b0;
         overrun_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         gap_cnt_q     <= gap_cnt_d;
         mask_q        <= mask_d;
         wr_frame_q    <= wr_frame_d;
         tmo_cnt_q     <= tmo_cnt_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_q       <= frame_d;
         seq_run_q     <= seq_run_d;
         frame_count_q <= frame_count_d;
         err_q         <= err_d;
`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
         ready_q       <= ready_d;
         overrun_q     <= overrun_d;
`endif
      end
   end

endmodule

// File: tb/tb_audio_frame_writer.sv
// Directed bench for audio_frame_writer: frame fill, sequencer handshake, ring wrap, duplicates, timeout, reset.
module tb_audio_frame_writer;
   logic        ck = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;
   logic [3:0]  frame;
   logic        seq_run;
   logic        seq_done;
   logic        seq_error;
   logic [15:0] frame_count;
   logic        err;
`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
   logic [15:0] overrun_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] ram [0:127];

   always #5 ck = ~ck;

   audio_frame_writer_if #(.CHAN_W(3)) in_if ();

   audio_frame_writer #(.CHAN_W(3), .FRAME_W(4), .TIMEOUT(1023)) dut (
      .ck          (ck),
      .rst         (rst),
      .in_if       (in_if),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame       (frame),
      .seq_run     (seq_run),
      .seq_done    (seq_done),
      .seq_error   (seq_error),
      .frame_count (frame_count),
      .err         (err)
`ifdef AUDIO_FRAME_WRITER_OVERRUN_EN
      ,
      .overrun_count (overrun_count)
`endif
   );

   // Behavioural audio RAM fed by the write strobe.
   always @(posedge ck) if (wr_en) ram[wr_addr] <= wr_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge ck);
         #1;
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_if.in_ready && n < 50) begin
         tick();
         n++;
      end
      check("wait_ready", in_if.in_ready, 1);
   endtask

   task automatic send(input logic [2:0] ch, input logic [15:0] d, input logic [3:0] fr);
      in_if.in_valid = 1'b1;
      in_if.in_chan  = ch;
      in_if.in_data  = d;
      wait_ready();
      tick();
      in_if.in_valid = 1'b0;
      check("wr_en", wr_en, 1);
      check("wr_addr", wr_addr, {ch, fr});
      check("wr_data", wr_data, d);
   endtask

   task automatic fill_frame(input logic [3:0] fr, input logic [15:0] base);
      for (int c = 0; c < 8; c++) send(3'(c), base + 16'(c), fr);
      check("ready_drop", in_if.in_ready, 0);
      tick();
      check("seq_run_up", seq_run, 1);
      check("frame", frame, fr);
   endtask

   task automatic finish_frame(input int delay, input logic [15:0] exp_count);
      tick(delay - 1);
      seq_done = 1'b1;
      tick();
      seq_done = 1'b0;
      check("seq_run_down", seq_run, 0);
      check("frame_count", frame_count, exp_count);
      check("gap_ready0", in_if.in_ready, 0);
      tick();
      check("gap_ready1", in_if.in_ready, 0);
      tick();
      check("gap_exit", in_if.in_ready, 1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, in_if.in_ready, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_frame"}, frame, 0);
      check({tag, "_seq_run"}, seq_run, 0);
      check({tag, "_frame_count"}, frame_count, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      int n;
      rst            = 1'b1;
      in_if.in_valid = 1'b0;
      in_if.in_chan  = '0;
      in_if.in_data  = '0;
      seq_done       = 1'b0;
      seq_error      = 1'b0;
      tick(2);
      check_reset("rst0");
      rst = 1'b0;
      wait_ready();

      // Frame 0, channels in order, then a long seq_done that holds GAP open.
      fill_frame(4'd0, 16'h1000);
      tick(19);
      seq_done = 1'b1;
      tick();
      check("f0_seq_run_down", seq_run, 0);
      check("f0_frame_count", frame_count, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("gap_held_by_done", in_if.in_ready, 0);
      end
      seq_done = 1'b0;
      tick();
      check("gap_release", in_if.in_ready, 1);

      // Frames 1..15 then wrap back to frame 0.
      for (int f = 1; f <= 16; f++) begin
         fill_frame(4'(f), 16'h2000 + 16'(f << 4));
         finish_frame(5, 16'(f + 1));
      end
      check("err_clean", err, 0);

      // Duplicate channel 3 in frame 1; second value must win.
      for (int c = 0; c < 4; c++) send(3'(c), 16'h3000 + 16'(c), 4'd1);
      send(3'd3, 16'hBEEF, 4'd1);
      check("dup_err", err, 1);
      check("dup_still_collect", in_if.in_ready, 1);
      for (int c = 4; c < 8; c++) send(3'(c), 16'h3000 + 16'(c), 4'd1);
      check("dup_ready_drop", in_if.in_ready, 0);
      tick();
      check("dup_seq_run", seq_run, 1);
      check("dup_frame", frame, 1);
      check("dup_ram", ram[7'h31], 16'hBEEF);
      finish_frame(3, 16'd18);
      check("err_sticky", err, 1);

      // Partial frame 2 aborted by reset; next frame restarts at frame 0 with an empty mask.
      for (int c = 0; c < 4; c++) send(3'(c), 16'h4000 + 16'(c), 4'd2);
      rst = 1'b1;
      tick();
      check_reset("rst1");
      rst = 1'b0;
      wait_ready();
      for (int c = 4; c < 8; c++) send(3'(c), 16'h4400 + 16'(c), 4'd0);
      check("mask_cleared", in_if.in_ready, 1);
      check("no_early_run", seq_run, 0);
      for (int c = 0; c < 4; c++) send(3'(c), 16'h4400 + 16'(c), 4'd0);
      tick();
      check("rst_frame_run", seq_run, 1);
      check("rst_frame_idx", frame, 0);

      // Sequencer never finishes: abort after 1023 RUN clocks.
      n = 0;
      while (seq_run && n < 2000) begin
         tick();
         n++;
      end
      check("timeout_len", n, 1023);
      check("timeout_err", err, 1);
      check("timeout_count", frame_count, 0);
      wait_ready();
      fill_frame(4'd1, 16'h5000);

      // Reset while the sequencer is running.
      rst = 1'b1;
      tick();
      check_reset("rst2");
      rst = 1'b0;
      wait_ready();

      // seq_error reported alongside seq_done.
      fill_frame(4'd0, 16'h6000);
      tick(3);
      seq_done  = 1'b1;
      seq_error = 1'b1;
      tick();
      seq_done  = 1'b0;
      seq_error = 1'b0;
      check("seqerr_run", seq_run, 0);
      check("seqerr_err", err, 1);
      check("seqerr_count", frame_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end
endmodule
